// File: rtl/fifo_pkt.sv
// fifo_pkt: packet FIFO with commit/abort semantics.
// Writes accumulate as "pending" words that the reader cannot see.
// A commit publishes them, and an abort rewinds the writer to the last
// commit point. The read side is first-word fall-through with registered
// read_data.
// Optional feature macro: FIFO_PKT_ERR_EN adds sticky overflow/underflow flags.
// Handshake: a write is taken when write_strobe=1 and count+pending < NUM.
// A read is taken when read_strobe=1 and count != 0.
// Requests that are not taken have no effect on FIFO state.
module fifo_pkt #(
  parameter int WIDTH  = 8,
  parameter int NUM    = 256,
  parameter int BITS   = $clog2(NUM),
  parameter int AFULL  = NUM - 4,
  parameter int AEMPTY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_strobe,
  input  logic             commit,
  input  logic             abort,
  output logic             space_available,
  output logic             almost_full,
  output logic [WIDTH-1:0] read_data,
  input  logic             read_strobe,
  output logic             data_available,
  output logic             more_available,
  output logic             almost_empty,
  output logic [BITS:0]    count,
  output logic [BITS:0]    pending
`ifdef FIFO_PKT_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam logic [BITS+1:0] NUM_W    = (BITS+2)'(NUM);
  localparam logic [BITS+1:0] AFULL_W  = (BITS+2)'(AFULL);
  localparam logic [BITS:0]   AEMPTY_W = (BITS+1)'(AEMPTY);
  localparam logic [BITS-1:0] PTR_ONE  = {{(BITS-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [NUM];

  logic [BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BITS-1:0]  cp_ptr_q, cp_ptr_d;
  logic [BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BITS:0]    count_q, count_d;
  logic [BITS:0]    pending_q, pending_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;

  logic [BITS+1:0]  total;
  logic             full;
  logic             wr_acc;
  logic             rd_acc;
  logic             mem_we;
  logic [BITS:0]    committed;
  logic [BITS:0]    rd_ext;

  assign total = {1'b0, count_q} + {1'b0, pending_q};
  assign full  = (total >= NUM_W);

  // Next-state computation for pointers, counters and the fall-through word.
  always_comb begin
    wr_acc      = write_strobe && !full;
    rd_acc      = read_strobe && (count_q != '0);
    // An aborted cycle never touches the RAM.
    mem_we      = wr_acc && !abort;
    committed   = pending_q + {{BITS{1'b0}}, wr_acc};
    rd_ext      = {{BITS{1'b0}}, rd_acc};
    wr_ptr_d    = wr_ptr_q;
    cp_ptr_d    = cp_ptr_q;
    pending_d   = pending_q;
    count_d     = count_q - rd_ext;
    rd_ptr_d    = rd_acc ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    read_data_d = read_data_q;

    if (abort) begin
      // Rewind to the last commit point. Abort wins over commit.
      wr_ptr_d  = cp_ptr_q;
      pending_d = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (commit) begin
        count_d   = count_q + committed - rd_ext;
        pending_d = '0;
        cp_ptr_d  = wr_ptr_d;
      end else if (wr_acc) begin
        pending_d = pending_q + {{BITS{1'b0}}, 1'b1};
      end
    end

    // Present the oldest committed word next cycle. If that slot is being
    // written right now, the word only exists on write_data. When count is
    // empty, read_data is held so uncommitted data never leaks out.
    if (count_d != '0) begin
      if (mem_we && (rd_ptr_d == wr_ptr_q)) begin
        read_data_d = write_data;
      end else begin
        read_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      cp_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pending_q   <= '0;
      read_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cp_ptr_q    <= cp_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      read_data_q <= read_data_d;
    end
  end

`ifdef FIFO_PKT_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags, set by refused requests and cleared only by reset.
  always_comb begin
    overflow_d  = overflow_q  | (write_strobe & full);
    underflow_d = underflow_q | (read_strobe & (count_q == '0));
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign space_available = !full;
  assign almost_full     = (total >= AFULL_W);
  assign read_data       = read_data_q;
  assign data_available  = (count_q != '0);
  assign more_available  = (count_q > {{BITS{1'b0}}, 1'b1});
  assign almost_empty    = (count_q <= AEMPTY_W);
  assign count           = count_q;
  assign pending         = pending_q;

endmodule

// File: tb/tb_fifo_pkt.sv
// Directed bench for fifo_pkt built with NUM=4 and AFULL=3, so wrap-around
// and full conditions are reached quickly. AEMPTY keeps its default of 2.
module tb_fifo_pkt;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] write_data;
  logic       write_strobe, commit, abort, read_strobe;
  logic       space_available, almost_full;
  logic [7:0] read_data;
  logic       data_available, more_available, almost_empty;
  logic [2:0] count, pending;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  fifo_pkt #(.WIDTH(8), .NUM(4), .AFULL(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .write_data      (write_data),
    .write_strobe    (write_strobe),
    .commit          (commit),
    .abort           (abort),
    .space_available (space_available),
    .almost_full     (almost_full),
    .read_data       (read_data),
    .read_strobe     (read_strobe),
    .data_available  (data_available),
    .more_available  (more_available),
    .almost_empty    (almost_empty),
    .count           (count),
    .pending         (pending)
`ifdef FIFO_PKT_ERR_EN
    ,
    .overflow        (overflow),
    .underflow       (underflow)
`endif
  );

`ifndef FIFO_PKT_ERR_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every status output against the expected committed/pending counts.
  task automatic status(input string tag, input int cnt, input int pend,
                        input logic [7:0] rd, input bit chk_rd);
    chk({tag, ".count"},   32'(count),           32'(cnt));
    chk({tag, ".pending"}, 32'(pending),         32'(pend));
    chk({tag, ".da"},      32'(data_available),  32'(cnt != 0));
    chk({tag, ".more"},    32'(more_available),  32'(cnt > 1));
    chk({tag, ".aempty"},  32'(almost_empty),    32'(cnt <= 2));
    chk({tag, ".space"},   32'(space_available), 32'((cnt + pend) < 4));
    chk({tag, ".afull"},   32'(almost_full),     32'((cnt + pend) >= 3));
    if (chk_rd) chk({tag, ".rdata"}, 32'(read_data), 32'(rd));
  endtask

  // Driver: apply one cycle of requests, then sample 1 ns after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic c,
                     input logic a, input logic r);
    write_strobe = w;
    write_data   = d;
    commit       = c;
    abort        = a;
    read_strobe  = r;
    @(posedge clk);
    #1;
    write_strobe = 1'b0;
    write_data   = 8'h00;
    commit       = 1'b0;
    abort        = 1'b0;
    read_strobe  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    write_strobe = 1'b0; write_data = 8'h00; commit = 1'b0;
    abort = 1'b0; read_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    status("reset", 0, 0, 8'h00, 1'b1);
    chk("reset.ovf", 32'(overflow), 32'd0);
    chk("reset.udf", 32'(underflow), 32'd0);
    reset = 1'b0;

    // Uncommitted writes stay invisible to the reader.
    cyc(1, 8'h11, 0, 0, 0); status("w11", 0, 1, 8'h00, 1'b1);
    cyc(1, 8'h22, 0, 0, 0); status("w22", 0, 2, 8'h00, 1'b1);
    // Commit together with the third write.
    cyc(1, 8'h33, 1, 0, 0); status("c33", 3, 0, 8'h11, 1'b1);
    cyc(0, 8'h00, 0, 0, 1); status("rd1", 2, 0, 8'h22, 1'b1);
    cyc(0, 8'h00, 0, 0, 1); status("rd2", 1, 0, 8'h33, 1'b1);
    cyc(0, 8'h00, 0, 0, 1); status("rd3", 0, 0, 8'h00, 1'b0);

    // Abort rewinds to the commit point; its same-cycle write is dropped.
    cyc(1, 8'hA0, 1, 0, 0); status("cA0", 1, 0, 8'hA0, 1'b1);
    cyc(1, 8'hB0, 0, 0, 0); status("wB0", 1, 1, 8'hA0, 1'b1);
    cyc(1, 8'hB1, 0, 0, 0); status("wB1", 1, 2, 8'hA0, 1'b1);
    cyc(1, 8'hEE, 0, 1, 0); status("abort", 1, 0, 8'hA0, 1'b1);
    cyc(0, 8'h00, 0, 0, 1); status("rdA0", 0, 0, 8'h00, 1'b0);
    cyc(1, 8'hC0, 1, 0, 0); status("cC0", 1, 0, 8'hC0, 1'b1);
    cyc(0, 8'h00, 0, 0, 1); status("rdC0", 0, 0, 8'h00, 1'b0);

    // With count=1, read and commit a new word in the same cycle (bypass).
    cyc(1, 8'h5A, 1, 0, 0); status("c5A", 1, 0, 8'h5A, 1'b1);
    cyc(1, 8'h6B, 1, 0, 1); status("rc6B", 1, 0, 8'h6B, 1'b1);
    cyc(0, 8'h00, 0, 0, 1); status("rd6B", 0, 0, 8'h00, 1'b0);

    // Fill to full, then attempt one more write.
    cyc(1, 8'hD0, 0, 0, 0); status("wD0", 0, 1, 8'h00, 1'b0);
    cyc(1, 8'hD1, 0, 0, 0); status("wD1", 0, 2, 8'h00, 1'b0);
    cyc(1, 8'hD2, 0, 0, 0); status("wD2", 0, 3, 8'h00, 1'b0);
    cyc(1, 8'hD3, 1, 0, 0); status("cD3", 4, 0, 8'hD0, 1'b1);
    cyc(1, 8'hFF, 0, 0, 0); status("full_drop", 4, 0, 8'hD0, 1'b1);
`ifdef FIFO_PKT_ERR_EN
    chk("full_drop.ovf", 32'(overflow), 32'd1);
`endif
    cyc(0, 8'h00, 1, 0, 0); status("empty_commit", 4, 0, 8'hD0, 1'b1);
    cyc(0, 8'h00, 0, 0, 1); status("rdD0", 3, 0, 8'hD1, 1'b1);

    // Sustained write+commit+read across pointer wrap, scored by queue.
    exp_q.push_back(8'hD1);
    exp_q.push_back(8'hD2);
    exp_q.push_back(8'hD3);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'hE0 + i));
      cyc(1, 8'(8'hE0 + i), 1, 0, 1);
      void'(exp_q.pop_front());
      status("wrap", 3, 0, exp_q[0], 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 0, 0, 1);
      void'(exp_q.pop_front());
      if (exp_q.size() != 0) status("drain", exp_q.size(), 0, exp_q[0], 1'b1);
      else status("drain", 0, 0, 8'h00, 1'b0);
    end

    // Read while empty is ignored.
    cyc(0, 8'h00, 0, 0, 1); status("rd_empty", 0, 0, 8'h00, 1'b0);
`ifdef FIFO_PKT_ERR_EN
    chk("rd_empty.udf", 32'(underflow), 32'd1);
    chk("rd_empty.ovf", 32'(overflow), 32'd1);
`endif

    // Reset mid-packet with count=2, pending=1, overriding other requests.
    cyc(1, 8'h71, 1, 0, 0); status("c71", 1, 0, 8'h71, 1'b1);
    cyc(1, 8'h72, 1, 0, 0); status("c72", 2, 0, 8'h71, 1'b1);
    cyc(1, 8'h73, 0, 0, 0); status("w73", 2, 1, 8'h71, 1'b1);
    reset = 1'b1;
    write_strobe = 1'b1; write_data = 8'h7F; commit = 1'b1; read_strobe = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    write_strobe = 1'b0; write_data = 8'h00; commit = 1'b0; read_strobe = 1'b0;
    status("rst_mid", 0, 0, 8'h00, 1'b1);
    chk("rst_mid.ovf", 32'(overflow), 32'd0);
    chk("rst_mid.udf", 32'(underflow), 32'd0);
    cyc(0, 8'h00, 0, 0, 0); status("post_rst", 0, 0, 8'h00, 1'b1);
    cyc(1, 8'h99, 1, 0, 0); status("c99", 1, 0, 8'h99, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
